// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: MEM/WB pipeline has priority, side-unit results queue in a FIFO.
// Optional build macro WB_ARB_PERF_EN adds the OConflictCnt performance counter output.
module wb_port_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [1:0]  IWB,
  input  logic [63:0] IDataMemory,
  input  logic [63:0] IAlu,
  input  logic [4:0]  IInstruction,
  input  logic        ISideValid,
  input  logic [63:0] ISideData,
  input  logic [4:0]  ISideRd,
  output logic        OSideReady,
  output logic        ORegWrite,
  output logic [4:0]  ORegAddr,
  output logic [63:0] ORegData,
  output logic        OStall
`ifdef WB_ARB_PERF_EN
  ,
  output logic [15:0] OConflictCnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT, STALL, GRANT} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [STV_W-1:0]   starve_q, starve_d;
  logic [68:0]        fifo_mem [DEPTH];
  logic               we_q;
  logic [4:0]         addr_q;
  logic [63:0]        data_q;
  logic               stall_q;

  logic               pipe_req, fifo_empty, push, pop;
  logic [63:0]        pipe_data;
  logic [68:0]        head;

  assign pipe_req   = IWB[1];
  assign pipe_data  = IWB[0] ? IDataMemory : IAlu;
  assign fifo_empty = (count_q == '0);
  // Ready follows the stored count only, so a same-cycle pop never reopens it early.
  assign OSideReady = Rst_n && (count_q != FULL_CNT);
  assign push       = ISideValid && OSideReady;
  assign pop        = !pipe_req && !fifo_empty;
  assign head       = fifo_mem[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
    starve_d = starve_q;
    if (pop) begin
      starve_d = '0;
    end else if (pipe_req && !fifo_empty && (starve_q != STV_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {ISideRd, ISideData};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      stall_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      starve_q <= starve_d;
      stall_q  <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      // Address 0 is never written, but the winner is still consumed.
      if (pipe_req) begin
        we_q   <= (IInstruction != 5'd0);
        addr_q <= IInstruction;
        data_q <= pipe_data;
      end else if (pop) begin
        we_q   <= (head[68:64] != 5'd0);
        addr_q <= head[68:64];
        data_q <= head[63:0];
      end else begin
        we_q   <= 1'b0;
        addr_q <= '0;
        data_q <= '0;
      end

      case (state_q)
        IDLE: begin
          if (count_d != '0) state_q <= WAIT;
        end
        WAIT: begin
          if (pipe_req && (starve_d == STV_MAX)) begin
            state_q <= STALL;
            stall_q <= 1'b1;
          end else if (count_d == '0) begin
            state_q <= IDLE;
          end
        end
        STALL: begin
          state_q <= GRANT;
        end
        GRANT: begin
          if (!fifo_empty && pipe_req) begin
            state_q <= STALL;
            stall_q <= 1'b1;
          end else begin
            state_q <= (count_d != '0) ? WAIT : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef WB_ARB_PERF_EN
  logic [15:0] conflict_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      conflict_q <= '0;
    end else if (pipe_req && !fifo_empty && (conflict_q != 16'hFFFF)) begin
      conflict_q <= conflict_q + 1'b1;
    end
  end

  assign OConflictCnt = conflict_q;
`endif

  assign ORegWrite = we_q;
  assign ORegAddr  = addr_q;
  assign ORegData  = data_q;
  assign OStall    = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter: directed vector table, reset corner cases, and random traffic
// checked against a queue-based reference model.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [1:0]  IWB;
  logic [63:0] IDataMemory, IAlu, ISideData;
  logic [4:0]  IInstruction, ISideRd;
  logic        ISideValid;
  logic        OSideReady, ORegWrite, OStall;
  logic [4:0]  ORegAddr;
  logic [63:0] ORegData;
`ifdef WB_ARB_PERF_EN
  logic [15:0] OConflictCnt;
`endif

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .IWB(IWB), .IDataMemory(IDataMemory), .IAlu(IAlu),
    .IInstruction(IInstruction), .ISideValid(ISideValid), .ISideData(ISideData),
    .ISideRd(ISideRd), .OSideReady(OSideReady), .ORegWrite(ORegWrite),
    .ORegAddr(ORegAddr), .ORegData(ORegData), .OStall(OStall)
`ifdef WB_ARB_PERF_EN
    , .OConflictCnt(OConflictCnt)
`endif
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: side results as a queue, a lost-cycle tally, and a stall/grant phase.
  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] d;
  } ent_t;
  ent_t m_q[$];
  int   m_starve;
  int   m_phase;  // 0 normal, 1 stall cycle, 2 grant cycle

  task automatic model_clear();
    m_q.delete();
    m_starve = 0;
    m_phase  = 0;
  endtask

  task automatic model_step(output logic ew, output logic [4:0] ea, output logic [63:0] ed,
                            output logic es);
    bit   pipe, nonempty, push, popped;
    ent_t e;
    pipe     = IWB[1];
    nonempty = (m_q.size() > 0);
    push     = ISideValid && (m_q.size() < DEPTH);
    popped   = 0;
    ew = 0; ea = 0; ed = 0;
    if (pipe) begin
      ea = IInstruction;
      ed = IWB[0] ? IDataMemory : IAlu;
      ew = (IInstruction != 0);
    end else if (nonempty) begin
      e = m_q.pop_front();
      ea = e.rd;
      ed = e.d;
      ew = (e.rd != 0);
      popped = 1;
    end
    if (push) m_q.push_back('{rd: ISideRd, d: ISideData});
    if (popped) m_starve = 0;
    else if (pipe && nonempty && m_starve < LIMIT) m_starve++;
    es = 0;
    if (m_phase == 0 && pipe && nonempty && m_starve == LIMIT) es = 1;
    if (m_phase == 2 && pipe && nonempty) es = 1;
    m_phase = es ? 1 : ((m_phase == 1) ? 2 : 0);
  endtask

  task automatic cycle_check(input string tag);
    logic ew, es;
    logic [4:0] ea;
    logic [63:0] ed;
    model_step(ew, ea, ed, es);
    @(posedge Clk); #1;
    chk({tag, "_we"}, ORegWrite, ew);
    if (ew) begin
      chk({tag, "_addr"}, ORegAddr, ea);
      chk({tag, "_data"}, ORegData, ed);
    end
    chk({tag, "_stall"}, OStall, es);
    chk({tag, "_ready"}, OSideReady, (m_q.size() < DEPTH));
    $display("%s: we=%0b addr=%0d data=%0h stall=%0b ready=%0b", tag, ORegWrite, ORegAddr,
             ORegData, OStall, OSideReady);
  endtask

  typedef struct {
    logic [1:0]  iwb;
    logic [63:0] alu;
    logic [63:0] dmem;
    logic [4:0]  inst;
    logic        sv;
    logic [63:0] sdata;
    logic [4:0]  srd;
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
    logic        stall;
    logic        ready;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [1:0] iwb, input logic [63:0] alu, input logic [63:0] dmem,
                     input logic [4:0] inst, input logic sv, input logic [63:0] sdata,
                     input logic [4:0] srd, input logic we, input logic [4:0] addr,
                     input logic [63:0] data, input logic stall, input logic ready);
    tbl.push_back('{iwb, alu, dmem, inst, sv, sdata, srd, we, addr, data, stall, ready});
  endtask

  task automatic drive(input logic [1:0] iwb, input logic [63:0] alu, input logic [4:0] inst,
                       input logic sv, input logic [63:0] sdata, input logic [4:0] srd);
    IWB = iwb; IAlu = alu; IDataMemory = 64'h0; IInstruction = inst;
    ISideValid = sv; ISideData = sdata; ISideRd = srd;
  endtask

  initial begin
    bit pr, bubble;
    Rst_n = 1'b0;
    drive(2'b00, 64'h0, 5'd0, 1'b0, 64'h0, 5'd0);

    // Directed rows: expected outputs are those visible after the edge that samples the row.
    add(2'b10, 64'h5, 64'h0,  5'd3, 1'b0, 64'h0,  5'd0, 1'b1, 5'd3, 64'h5,  1'b0, 1'b1);
    add(2'b11, 64'h5, 64'hAA, 5'd3, 1'b0, 64'h0,  5'd0, 1'b1, 5'd3, 64'hAA, 1'b0, 1'b1);
    add(2'b00, 64'h0, 64'h0,  5'd0, 1'b1, 64'h77, 5'd9, 1'b0, 5'd0, 64'h0,  1'b0, 1'b1);
    add(2'b00, 64'h0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b1, 5'd9, 64'h77, 1'b0, 1'b1);
    add(2'b00, 64'h0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b0, 5'd0, 64'h0,  1'b0, 1'b1);
    add(2'b10, 64'h1, 64'h0,  5'd4, 1'b1, 64'hA1, 5'd5, 1'b1, 5'd4, 64'h1,  1'b0, 1'b1);
    add(2'b10, 64'h2, 64'h0,  5'd4, 1'b1, 64'hA2, 5'd6, 1'b1, 5'd4, 64'h2,  1'b0, 1'b0);
    add(2'b10, 64'h3, 64'h0,  5'd4, 1'b1, 64'hA3, 5'd7, 1'b1, 5'd4, 64'h3,  1'b0, 1'b0);
    add(2'b10, 64'h4, 64'h0,  5'd4, 1'b0, 64'h0,  5'd0, 1'b1, 5'd4, 64'h4,  1'b0, 1'b0);
    add(2'b10, 64'h5, 64'h0,  5'd4, 1'b0, 64'h0,  5'd0, 1'b1, 5'd4, 64'h5,  1'b1, 1'b0);
    add(2'b10, 64'h6, 64'h0,  5'd4, 1'b0, 64'h0,  5'd0, 1'b1, 5'd4, 64'h6,  1'b0, 1'b0);
    add(2'b00, 64'h0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b1, 5'd5, 64'hA1, 1'b0, 1'b1);
    add(2'b00, 64'h0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b1, 5'd6, 64'hA2, 1'b0, 1'b1);
    add(2'b10, 64'h9, 64'h0,  5'd0, 1'b1, 64'hB0, 5'd0, 1'b0, 5'd0, 64'h0,  1'b0, 1'b1);
    add(2'b00, 64'h0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b0, 5'd0, 64'h0,  1'b0, 1'b1);
    add(2'b00, 64'h0, 64'h0,  5'd0, 1'b1, 64'hC7, 5'd7, 1'b0, 5'd0, 64'h0,  1'b0, 1'b1);
    add(2'b00, 64'h0, 64'h0,  5'd0, 1'b0, 64'h0,  5'd0, 1'b1, 5'd7, 64'hC7, 1'b0, 1'b1);

    repeat (2) @(posedge Clk);
    #1;
    chk("rst_we", ORegWrite, 1'b0);
    chk("rst_addr", ORegAddr, 5'd0);
    chk("rst_data", ORegData, 64'h0);
    chk("rst_stall", OStall, 1'b0);
    chk("rst_ready", OSideReady, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    chk("post_rst_ready", OSideReady, 1'b1);

    for (int i = 0; i < tbl.size(); i++) begin
      IWB = tbl[i].iwb; IAlu = tbl[i].alu; IDataMemory = tbl[i].dmem;
      IInstruction = tbl[i].inst; ISideValid = tbl[i].sv;
      ISideData = tbl[i].sdata; ISideRd = tbl[i].srd;
      @(posedge Clk); #1;
      chk($sformatf("vec%0d_we", i), ORegWrite, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_addr", i), ORegAddr, tbl[i].addr);
        chk($sformatf("vec%0d_data", i), ORegData, tbl[i].data);
      end
      chk($sformatf("vec%0d_stall", i), OStall, tbl[i].stall);
      chk($sformatf("vec%0d_ready", i), OSideReady, tbl[i].ready);
      $display("vec%0d: we=%0b addr=%0d data=%0h stall=%0b ready=%0b", i, ORegWrite, ORegAddr,
               ORegData, OStall, OSideReady);
    end

    // Reset while two side entries are queued and a stall is being requested.
    model_clear();
    drive(2'b10, 64'h11, 5'd1, 1'b1, 64'hD1, 5'd10); cycle_check("mid_fill0");
    drive(2'b10, 64'h12, 5'd1, 1'b1, 64'hD2, 5'd11); cycle_check("mid_fill1");
    drive(2'b10, 64'h13, 5'd1, 1'b0, 64'h0,  5'd0);  cycle_check("mid_lose0");
    cycle_check("mid_lose1");
    cycle_check("mid_lose2");
    chk("stall_before_reset", OStall, 1'b1);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("async_rst_we", ORegWrite, 1'b0);
    chk("async_rst_addr", ORegAddr, 5'd0);
    chk("async_rst_data", ORegData, 64'h0);
    chk("async_rst_stall", OStall, 1'b0);
    chk("async_rst_ready", OSideReady, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    model_clear();
    drive(2'b00, 64'h0, 5'd0, 1'b0, 64'h0, 5'd0);
    for (int i = 0; i < 4; i++) cycle_check($sformatf("no_stale%0d", i));

`ifdef WB_ARB_PERF_EN
    drive(2'b10, 64'h21, 5'd2, 1'b1, 64'hE1, 5'd12); cycle_check("perf_push");
    drive(2'b10, 64'h22, 5'd2, 1'b0, 64'h0,  5'd0);
    for (int i = 0; i < 3; i++) cycle_check($sformatf("perf_conf%0d", i));
    chk("conflict_cnt", OConflictCnt, 16'd3);
    drive(2'b00, 64'h0, 5'd0, 1'b0, 64'h0, 5'd0);    cycle_check("perf_drain");
`endif

    bubble = 0;
    for (int i = 0; i < 300; i++) begin
      pr = ($urandom_range(0, 9) < 7);
      if (bubble && $urandom_range(0, 9) != 0) pr = 0;
      IWB          = {pr, 1'($urandom_range(0, 1))};
      IAlu         = {$urandom, $urandom};
      IDataMemory  = {$urandom, $urandom};
      IInstruction = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ISideValid   = ($urandom_range(0, 2) != 0);
      ISideData    = {$urandom, $urandom};
      ISideRd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle_check($sformatf("rnd%0d", i));
      bubble = OStall;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
